jpeg_bit_packer: RTL and testbench
==================================

JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port bit_in, input, 1, serial entropy-coded bit from the upstream decision stage.
REQ-004 SHALL have port bit_valid, input, 1, bit_in qualifier.
REQ-005 SHALL have port bit_ready, output, 1, packer can accept a bit this cycle.
REQ-006 SHALL have port flush, input, 1, end-of-scan request: pad and emit the partial byte.
REQ-007 SHALL have port out_data, output, 8, packed byte, MSB = earliest bit.
REQ-008 SHALL have port out_valid, output, 1, out_data qualifier.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-010 SHALL have port out_is_stuff, output, 1, current out_data is an inserted 0x00.
REQ-011 SHALL have port flush_done, output, 1, one-cycle pulse when the flush completes.

Function
REQ-012 SHALL use states ACCUM, EMIT_BYTE, EMIT_STUFF, DONE, plus an 8-bit shift register sreg, a 3-bit count cnt and a flush_pend flag.
REQ-013 SHALL drive bit_ready=1 only in ACCUM; a bit transfers when bit_valid&&bit_ready.
REQ-014 SHALL, on transfer, set sreg={sreg[6:0],bit_in} and cnt=cnt+1 (mod 8).
REQ-015 SHALL, when the transfer makes 8 bits (cnt==7), latch the byte into out_data and enter EMIT_BYTE next cycle.
REQ-016 SHALL drive out_valid=1 only in EMIT_BYTE/EMIT_STUFF; out_data and out_is_stuff held stable while out_valid&&!out_ready.
REQ-017 SHALL, on EMIT_BYTE handshake: out_data==0xFF -> EMIT_STUFF; else flush_pend -> DONE; else -> ACCUM.
REQ-018 SHALL in EMIT_STUFF present out_data=0x00, out_is_stuff=1; on handshake -> DONE if flush_pend, else ACCUM.
REQ-019 SHALL sample flush only in ACCUM; flush with a simultaneous bit transfer includes that bit before flushing.
REQ-020 SHALL on flush in ACCUM set flush_pend; if the resulting cnt is 0 and no byte completed -> DONE with no byte emitted.
REQ-021 SHALL otherwise pad the partial byte with 1s in the LSBs (cnt bits kept in MSBs), reset cnt to 0 and enter EMIT_BYTE; padding yielding 0xFF is stuffed per REQ-017.
REQ-022 SHALL in DONE assert flush_done for exactly one cycle, clear flush_pend, return to ACCUM.
REQ-023 SHALL ignore flush outside ACCUM (no queuing); flush while flush_pend is set has no extra effect.
REQ-024 SHALL deliver at most one byte per handshake; minimum byte latency: last bit accepted at cycle t -> out_valid at t+1.

Reset
REQ-025 SHALL on rst=1 set state=ACCUM, sreg=0, cnt=0, flush_pend=0 next edge.
REQ-026 SHALL reset outputs to bit_ready=1 (after reset release), out_valid=0, out_data=0x00, out_is_stuff=0, flush_done=0.
REQ-027 SHALL let rst override any in-flight EMIT_BYTE/EMIT_STUFF/flush; the pending byte is discarded.

Configuration
REQ-028 SHALL, when JPEG_PACKER_STUFF_EN is defined, perform 0xFF->0x00 stuffing per REQ-017/018.
REQ-029 SHALL, when JPEG_PACKER_STUFF_EN is undefined, omit EMIT_STUFF: after 0xFF go directly to DONE/ACCUM and tie out_is_stuff=0.

Verification
REQ-030 SHALL cover: bits 1,0,1,1,0,0,1,0, out_ready=1 -> single byte 0xB2, out_is_stuff=0.
REQ-031 SHALL cover: eight 1 bits -> 0xFF then 0x00 with out_is_stuff=1 (stuff enabled); only 0xFF when disabled.
REQ-032 SHALL cover: bits 1,0,1 then flush -> 0xBF, then flush_done pulse one cycle after handshake.
REQ-033 SHALL cover: flush with cnt=0 and bit_valid=0 -> no byte, flush_done one cycle later.
REQ-034 SHALL cover: out_ready low 5 cycles in EMIT_BYTE -> out_data stable, bit_ready=0 throughout, byte delivered once.
REQ-035 SHALL cover: rst pulsed during EMIT_STUFF -> out_valid=0 next cycle, next 8 bits form a fresh byte.

Source files
------------

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs serial bits into bytes, pads on flush, stuffs 0x00 after 0xFF when JPEG_PACKER_STUFF_EN is defined
module jpeg_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_is_stuff,
  output logic       flush_done
);
  typedef enum logic [1:0] {ACCUM, EMIT_BYTE, EMIT_STUFF, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] sreg_q, sreg_d, data_q, data_d, ns, pad;
  logic [2:0] cnt_q, cnt_d, nc;
  logic       flush_pend_q, flush_pend_d, xfer;
  // next-state: accumulate bits, complete or pad a byte, walk the emit/stuff/done sequence
  always_comb begin
    xfer = bit_valid && state_q == ACCUM;
    ns = xfer ? {sreg_q[6:0], bit_in} : sreg_q;
    nc = cnt_q + {2'b0, xfer};
    pad = (ns << (4'd8 - {1'b0, nc})) | (8'hFF >> nc);
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    data_d = data_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      ACCUM: begin
        sreg_d = ns;
        cnt_d = nc;
        if (xfer && cnt_q == 3'd7) begin
          data_d = ns;
          state_d = EMIT_BYTE;
          flush_pend_d = flush_pend_q | flush;
        end else if (flush) begin
          flush_pend_d = 1'b1;
          cnt_d = 3'd0;
          data_d = nc != 3'd0 ? pad : data_q;
          state_d = nc != 3'd0 ? EMIT_BYTE : DONE;
        end
      end
      EMIT_BYTE: if (out_ready) begin
`ifdef JPEG_PACKER_STUFF_EN
        if (data_q == 8'hFF) begin
          state_d = EMIT_STUFF;
          data_d = 8'h00;
        end else
`endif
        state_d = flush_pend_q ? DONE : ACCUM;
      end
      EMIT_STUFF: if (out_ready) state_d = flush_pend_q ? DONE : ACCUM;
      DONE: begin
        flush_pend_d = 1'b0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end
  // state registers; reset drops any byte in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      sreg_q <= 8'h00;
      cnt_q <= 3'd0;
      data_q <= 8'h00;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      flush_pend_q <= flush_pend_d;
    end
  end
  assign bit_ready = state_q == ACCUM;
  assign out_valid = state_q == EMIT_BYTE || state_q == EMIT_STUFF;
  assign out_data = data_q;
  assign flush_done = state_q == DONE;
`ifdef JPEG_PACKER_STUFF_EN
  assign out_is_stuff = state_q == EMIT_STUFF;
`else
  assign out_is_stuff = 1'b0;
`endif
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: vector table, hand sequences and a randomized queue-model run for jpeg_bit_packer
module tb_jpeg_bit_packer;
`ifdef JPEG_PACKER_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, bit_ready, flush, out_valid, out_ready, out_is_stuff, flush_done;
  logic [7:0] out_data;
  int pass_cnt = 0;
  int total = 0;
  logic [8:0] got_q[$];
  int dones;
  logic [8:0] exp_q[$];
  bit bits_q[$];
  int pend;
  always #5 clk = ~clk;
  jpeg_bit_packer dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_stuff(out_is_stuff), .flush_done(flush_done)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic feed(input logic [7:0] bits, input int n, input bit fl);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in = bits[n-1-i];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    if (fl) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
  endtask
  task automatic collect(input int n);
    got_q.delete();
    dones = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (out_valid) got_q.push_back({out_is_stuff, out_data});
      if (flush_done) dones++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask
  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    if (STUFF && b == 8'hFF) exp_q.push_back(9'h100);
  endtask
  task automatic model_bit(input bit b);
    logic [7:0] v;
    bits_q.push_back(b);
    if (bits_q.size() == 8) begin
      v = 8'h00;
      for (int i = 0; i < 8; i++) v = {v[6:0], bits_q[i]};
      push_byte(v);
      bits_q.delete();
    end
  endtask
  task automatic model_flush();
    logic [7:0] v;
    pend++;
    if (bits_q.size() > 0) begin
      v = 8'h00;
      for (int i = 0; i < 8; i++) v = {v[6:0], i < bits_q.size() ? bits_q[i] : 1'b1};
      push_byte(v);
      bits_q.delete();
    end
  endtask
  task automatic step(input bit bv, input bit bi, input bit fl, input bit orr);
    logic [8:0] e;
    if (flush_done) begin
      check("done_after_bytes", exp_q.size(), 0);
      check("done_expected", int'(pend > 0), 1);
      if (pend > 0) pend--;
    end
    check("ready_valid_exclusive", int'(bit_ready && out_valid), 0);
    bit_valid = bv;
    bit_in = bi;
    flush = fl;
    out_ready = orr;
    if (out_valid && out_ready) begin
      check("byte_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rand_byte", {out_is_stuff, out_data}, e);
      end
    end
    if (bit_ready && bit_valid) model_bit(bit_in);
    if (bit_ready && flush) model_flush();
    @(negedge clk);
  endtask
  typedef struct {
    logic [7:0] bits;
    int         n;
    bit         fl;
    int         nb;
    logic [8:0] b0;
    logic [8:0] b1;
    int         nd;
  } vec_t;
  vec_t tbl[8];
  logic [8:0] ex[2];
  initial begin
    tbl[0] = '{8'hB2, 8, 1'b0, 1, 9'h0B2, 9'h000, 0};
    tbl[1] = '{8'hFF, 8, 1'b0, 1 + int'(STUFF), 9'h0FF, 9'h100, 0};
    tbl[2] = '{8'h05, 3, 1'b1, 1, 9'h0BF, 9'h000, 1};
    tbl[3] = '{8'h00, 0, 1'b1, 0, 9'h000, 9'h000, 1};
    tbl[4] = '{8'h00, 8, 1'b0, 1, 9'h000, 9'h000, 0};
    tbl[5] = '{8'h7F, 7, 1'b1, 1 + int'(STUFF), 9'h0FF, 9'h100, 1};
    tbl[6] = '{8'h00, 1, 1'b1, 1, 9'h07F, 9'h000, 1};
    tbl[7] = '{8'h16, 5, 1'b1, 1, 9'h0B7, 9'h000, 1};
    do_reset();
    check("rst_bit_ready", bit_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_is_stuff", out_is_stuff, 0);
    check("rst_flush_done", flush_done, 0);
    for (int k = 0; k < 8; k++) begin
      do_reset();
      feed(tbl[k].bits, tbl[k].n, tbl[k].fl);
      collect(12);
      ex[0] = tbl[k].b0;
      ex[1] = tbl[k].b1;
      check($sformatf("vec%0d_nbytes", k), got_q.size(), tbl[k].nb);
      check($sformatf("vec%0d_dones", k), dones, tbl[k].nd);
      for (int j = 0; j < got_q.size() && j < tbl[k].nb; j++)
        check($sformatf("vec%0d_byte%0d", k, j), got_q[j], ex[j]);
    end
    do_reset();
    feed(8'hA5, 8, 1'b0);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_data", out_data, 8'hA5);
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", out_data, 8'hA5);
      check("stall_valid", out_valid, 1);
      check("stall_bit_ready", bit_ready, 0);
    end
    flush = 1'b0;
    collect(8);
    check("stall_once", got_q.size(), 1);
    check("stall_no_flush", dones, 0);
    do_reset();
    feed(8'h05, 3, 1'b1);
    check("flush_valid", out_valid, 1);
    check("flush_data", out_data, 8'hBF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("flush_done_pulse", flush_done, 1);
    check("flush_valid_off", out_valid, 0);
    @(negedge clk);
    check("flush_done_once", flush_done, 0);
    check("flush_back_ready", bit_ready, 1);
    do_reset();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("empty_flush_done", flush_done, 1);
    check("empty_flush_novalid", out_valid, 0);
    @(negedge clk);
    check("empty_flush_once", flush_done, 0);
    do_reset();
    feed(8'hFF, 8, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stuff_phase", out_is_stuff, int'(STUFF));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    feed(8'h3C, 8, 1'b0);
    collect(6);
    check("rst_mid_nbytes", got_q.size(), 1);
    check("rst_mid_byte", got_q.size() > 0 ? got_q[0] : 9'h1FF, 9'h03C);
    do_reset();
    exp_q.delete();
    bits_q.delete();
    pend = 0;
    for (int c = 0; c < 4000; c++)
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
    for (int c = 0; c < 40; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_dones", pend, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
